lcd_line_arbiter: RTL and testbench
===================================

Name: lcd_line_arbiter

Overview:
- Shares the single LCD character-write port (row/col/char/we plus update) between two line-writer clients, e.g. a status line and a channel/number line.
- Each client submits a whole line of up to 16 characters in one request.
- The arbiter grants clients round-robin, streams the characters one per cycle, issues the update strobe and waits for the LCD driver to go idle.
- It sits between the client logic and the LCD driver; the driver provides lcd_busy.

Parameters:
- NCHAR, 16, maximum characters per line; also the width of the column index range.
- CW, 4, width of lcd_col; must satisfy 2^CW >= NCHAR.

Ports:
- CLK  in  1  system clock.
- RST  in  1  asynchronous, active-high reset.
- req0  in  1  client 0 requests a line write; level, sampled in IDLE.
- row0  in  1  client 0 target row.
- len0  in  5  client 0 character count, 0..31; values >NCHAR are clamped to NCHAR.
- data0  in  8*NCHAR  client 0 characters; char k is data0[8k+7:8k].
- gnt0  out  1  one-cycle pulse: client 0 request accepted and inputs latched.
- done0  out  1  one-cycle pulse: client 0 line written and update complete.
- req1, row1, len1, data1, gnt1, done1: same as above, for client 1.
- lcd_row  out  1  row for the current write.
- lcd_col  out  CW  column for the current write.
- lcd_char  out  8  character for the current write.
- lcd_we  out  1  write strobe, one character per cycle when high.
- update  out  1  one-cycle refresh strobe to the LCD driver.
- lcd_busy  in  1  LCD driver busy (initialising or refreshing).
- owner  out  1  client currently served; valid while active is 1.
- active  out  1  a transaction is in progress (any state other than WAIT_INIT/IDLE).

Behaviour:
- Reset: async on RST=1. State goes to WAIT_INIT, column index to 0, round-robin pointer to client 0. All outputs are 0.
  - Reset mid-transaction aborts immediately; no done pulse is issued.
- States: WAIT_INIT, IDLE, WRITE, UPDATE, WAIT_IDLE, DONE.
- WAIT_INIT -> IDLE on the first edge with lcd_busy=0.
- IDLE, no request: stay.
- IDLE, request present: pick the winner.
  - Only one client requesting: that client wins.
  - Both requesting: the client the pointer designates wins. The pointer designates the client not served last; client 0 after reset.
  - On the edge: latch row, clamped len and data of the winner; set owner; idx=0.
  - Next cycle: gnt of the winner is 1 for exactly one cycle.
  - Next state: WRITE if the clamped len is >0, otherwise UPDATE.
- Latched data is authoritative. req, row, len and data changes after acceptance are ignored until DONE.
- WRITE:
  - lcd_row = latched row, lcd_col = idx, lcd_char = latched char idx.
  - lcd_we = !lcd_busy. When lcd_busy=1, lcd_we=0 and idx holds; the write stalls, nothing is lost.
  - On each edge with lcd_we=1, idx increments. After writing idx=len-1, go to UPDATE.
  - A len-N line therefore takes N cycles with no busy stalls. The first lcd_we is in the same cycle as gnt.
- lcd_col, lcd_char and lcd_row are 0 outside WRITE.
- UPDATE: update=1 for one cycle, then WAIT_IDLE.
- WAIT_IDLE: minimum one cycle. Exits to DONE on the first edge in this state with lcd_busy=0.
- DONE:
  - done of the owner = 1 for one cycle.
  - Pointer is set to the other client.
  - Next state is IDLE.
  - A request is never accepted in the DONE cycle, so there is always at least one IDLE cycle between transactions.
- A client that holds req high after done is re-granted only if the other client is not requesting.
- Total latency with no stalls, from the accepting edge to the done pulse: len + 3 cycles, counting the WRITE, UPDATE, WAIT_IDLE and DONE cycles.
- Invariants:
  - gnt0 and gnt1 are never high together; the same holds for done0/done1.
  - lcd_we never asserts outside WRITE.
  - lcd_col < clamped len.

Test Plan:
- Reset, lcd_busy=1 for 5 cycles then 0 -> active stays 0, no gnt; IDLE reached 1 cycle after lcd_busy falls.
- req0=1, row0=1, len0=3, data0 chars "ABC", lcd_busy=0 -> gnt0 one cycle later. lcd_we high for 3 cycles with col 0,1,2 and char 0x41,0x42,0x43, row 1. Then update pulse, then done0 pulse 6 cycles after the accepting edge.
- req0 and req1 asserted together and held -> client 0 is served first, then client 1, then client 0. Grants alternate; never two gnt or two done in the same cycle.
- Client 1, len1=4, lcd_busy=1 for 2 cycles during the 2nd char -> lcd_we=0 and col held at 1 for 2 cycles. All 4 chars are written exactly once; done1 comes 2 cycles later than the unstalled case.
- len0=0 -> gnt0, update with no lcd_we, done0. Separately, len0=20 -> exactly 16 writes, col 0..15.
- RST pulsed during WRITE at col 5 -> all outputs 0 immediately, no done0. After lcd_busy=0 and req0 held, the transaction restarts from col 0 with a fresh gnt0.

Source files
------------

// File: rtl/lcd_line_arbiter_if.sv
// Signal bundle between two LCD line-writer clients, the line arbiter and the LCD driver.
// The master side is the client/driver environment; the slave side is the arbiter.
interface lcd_line_arbiter_if #(
  parameter int NCHAR = 16,
  parameter int CW    = 4
);
  logic                 req0;
  logic                 row0;
  logic [4:0]           len0;
  logic [8*NCHAR-1:0]   data0;
  logic                 gnt0;
  logic                 done0;

  logic                 req1;
  logic                 row1;
  logic [4:0]           len1;
  logic [8*NCHAR-1:0]   data1;
  logic                 gnt1;
  logic                 done1;

  logic                 lcd_row;
  logic [CW-1:0]        lcd_col;
  logic [7:0]           lcd_char;
  logic                 lcd_we;
  logic                 update;
  logic                 lcd_busy;
  logic                 owner;
  logic                 active;

  modport master (
    output req0, row0, len0, data0,
    output req1, row1, len1, data1,
    output lcd_busy,
    input  gnt0, done0, gnt1, done1,
    input  lcd_row, lcd_col, lcd_char, lcd_we, update, owner, active
  );

  modport slave (
    input  req0, row0, len0, data0,
    input  req1, row1, len1, data1,
    input  lcd_busy,
    output gnt0, done0, gnt1, done1,
    output lcd_row, lcd_col, lcd_char, lcd_we, update, owner, active
  );
endinterface

// File: rtl/lcd_line_arbiter.sv
// Round-robin arbiter sharing one LCD character-write port between two line-writer clients.
// A granted line is latched, streamed one character per cycle, then refreshed with an update strobe.
module lcd_line_arbiter #(
  parameter int NCHAR = 16,
  parameter int CW    = 4
) (
  input logic               clk,
  input logic               rst,
  lcd_line_arbiter_if.slave arb
);
  localparam int LW = $clog2(NCHAR + 1);

  typedef enum logic [2:0] {
    S_WAIT_INIT = 3'd0,
    S_IDLE      = 3'd1,
    S_WRITE     = 3'd2,
    S_UPDATE    = 3'd3,
    S_WAIT_IDLE = 3'd4,
    S_DONE      = 3'd5
  } state_t;

  state_t              state_q;
  logic [CW-1:0]       idx_q;
  logic                rr_q;
  logic                owner_q;
  logic                row_q;
  logic [LW-1:0]       len_q;
  logic [8*NCHAR-1:0]  data_q;
  logic                gnt0_q;
  logic                gnt1_q;
  logic                done0_q;
  logic                done1_q;
  logic                update_q;

  logic                win_d;
  logic                any_req_d;
  logic                win_row_d;
  logic [LW-1:0]       win_len_d;
  logic [8*NCHAR-1:0]  win_data_d;
  logic                in_write_d;
  logic                we_d;
  logic                last_d;

  function automatic logic [LW-1:0] clamp_len(input logic [4:0] len);
    logic [LW-1:0] res;
    if (32'(len) > NCHAR) begin
      res = LW'(NCHAR);
    end else begin
      res = LW'(len);
    end
    return res;
  endfunction

  // A lone requester wins outright; a tie goes to the client the pointer designates.
  always_comb begin
    win_d = rr_q;
    if (arb.req0 && !arb.req1) begin
      win_d = 1'b0;
    end else if (arb.req1 && !arb.req0) begin
      win_d = 1'b1;
    end else begin
      win_d = rr_q;
    end
  end

  assign any_req_d  = arb.req0 | arb.req1;
  assign win_row_d  = win_d ? arb.row1 : arb.row0;
  assign win_len_d  = clamp_len(win_d ? arb.len1 : arb.len0);
  assign win_data_d = win_d ? arb.data1 : arb.data0;

  // The write strobe follows lcd_busy in the same cycle so a stall never drops a character.
  assign in_write_d = (state_q == S_WRITE);
  assign we_d       = in_write_d & ~arb.lcd_busy;
  assign last_d     = (LW'(idx_q) == (len_q - LW'(1'b1)));

  // Arbitration and line-streaming state machine.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_WAIT_INIT;
      idx_q    <= {CW{1'b0}};
      rr_q     <= 1'b0;
      owner_q  <= 1'b0;
      row_q    <= 1'b0;
      len_q    <= {LW{1'b0}};
      data_q   <= {(8*NCHAR){1'b0}};
      gnt0_q   <= 1'b0;
      gnt1_q   <= 1'b0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
      update_q <= 1'b0;
    end else begin
      gnt0_q   <= 1'b0;
      gnt1_q   <= 1'b0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
      update_q <= 1'b0;
      case (state_q)
        S_WAIT_INIT: begin
          if (!arb.lcd_busy) begin
            state_q <= S_IDLE;
          end else begin
            state_q <= S_WAIT_INIT;
          end
        end
        S_IDLE: begin
          if (any_req_d) begin
            owner_q <= win_d;
            row_q   <= win_row_d;
            len_q   <= win_len_d;
            data_q  <= win_data_d;
            idx_q   <= {CW{1'b0}};
            gnt0_q  <= ~win_d;
            gnt1_q  <= win_d;
            if (win_len_d != {LW{1'b0}}) begin
              state_q <= S_WRITE;
            end else begin
              state_q  <= S_UPDATE;
              update_q <= 1'b1;
            end
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_WRITE: begin
          if (we_d && last_d) begin
            idx_q    <= {CW{1'b0}};
            state_q  <= S_UPDATE;
            update_q <= 1'b1;
          end else if (we_d) begin
            idx_q <= idx_q + CW'(1'b1);
          end else begin
            idx_q <= idx_q;
          end
        end
        S_UPDATE: begin
          state_q <= S_WAIT_IDLE;
        end
        S_WAIT_IDLE: begin
          if (!arb.lcd_busy) begin
            state_q <= S_DONE;
            done0_q <= ~owner_q;
            done1_q <= owner_q;
          end else begin
            state_q <= S_WAIT_IDLE;
          end
        end
        S_DONE: begin
          rr_q    <= ~owner_q;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_WAIT_INIT;
        end
      endcase
    end
  end

  assign arb.gnt0     = gnt0_q;
  assign arb.gnt1     = gnt1_q;
  assign arb.done0    = done0_q;
  assign arb.done1    = done1_q;
  assign arb.update   = update_q;
  assign arb.owner    = owner_q;
  assign arb.active   = (state_q != S_WAIT_INIT) && (state_q != S_IDLE);
  assign arb.lcd_we   = we_d;
  assign arb.lcd_row  = in_write_d & row_q;
  assign arb.lcd_col  = in_write_d ? idx_q : {CW{1'b0}};
  assign arb.lcd_char = in_write_d ? data_q[{idx_q, 3'b000} +: 8] : 8'h00;
endmodule

// File: tb/tb_lcd_line_arbiter.sv
// Self-checking bench for lcd_line_arbiter: directed and randomised line writes against a
// line-level model (expected character stream, grant order and done latency per line).
module tb_lcd_line_arbiter;
  localparam int NCHAR = 16;
  localparam int CW    = 4;

  logic clk;
  logic rst;

  lcd_line_arbiter_if #(.NCHAR(NCHAR), .CW(CW)) bus ();
  lcd_line_arbiter #(.NCHAR(NCHAR), .CW(CW)) dut (.clk(clk), .rst(rst), .arb(bus));

  typedef struct packed {
    logic          row;
    logic [CW-1:0] col;
    logic [7:0]    ch;
  } wr_t;

  int  checks = 0;
  int  errors = 0;
  int  cyc    = 0;
  int  upd_n  = 0;
  int  last_served = 1;
  wr_t wq[$];
  int  gnt_c[$];
  int  gnt_t[$];
  int  done_c[$];
  int  done_t[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return 32'({bus.gnt0, bus.done0, bus.gnt1, bus.done1, bus.lcd_row, bus.lcd_col,
                bus.lcd_char, bus.lcd_we, bus.update, bus.owner, bus.active});
  endfunction

  // Observe every output on the falling edge and record events for the line-level model.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.lcd_we) wq.push_back({bus.lcd_row, bus.lcd_col, bus.lcd_char});
      if (bus.gnt0)  begin gnt_c.push_back(0);  gnt_t.push_back(cyc);  end
      if (bus.gnt1)  begin gnt_c.push_back(1);  gnt_t.push_back(cyc);  end
      if (bus.done0) begin done_c.push_back(0); done_t.push_back(cyc); end
      if (bus.done1) begin done_c.push_back(1); done_t.push_back(cyc); end
      if (bus.update) upd_n++;
      if (bus.gnt0 | bus.gnt1 | bus.done0 | bus.done1 | bus.lcd_we) begin
        chk("gnt_exclusive", 32'(bus.gnt0 & bus.gnt1), 32'd0);
        chk("done_exclusive", 32'(bus.done0 & bus.done1), 32'd0);
        chk("we_outside_txn", 32'(bus.lcd_we & ~bus.active), 32'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_obs();
    wq.delete();
    gnt_c.delete();
    gnt_t.delete();
    done_c.delete();
    done_t.delete();
    upd_n = 0;
  endtask

  task automatic drive_client(input int c, input logic req, input logic row, input logic [4:0] len,
                              input logic [8*NCHAR-1:0] data);
    if (c == 0) begin
      bus.req0 = req; bus.row0 = row; bus.len0 = len; bus.data0 = data;
    end else begin
      bus.req1 = req; bus.row1 = row; bus.len1 = len; bus.data1 = data;
    end
  endtask

  function automatic logic [8*NCHAR-1:0] rand_data();
    logic [8*NCHAR-1:0] d;
    d = '0;
    for (int i = 0; i < NCHAR / 4; i++) d[32*i +: 32] = $urandom();
    return d;
  endfunction

  // One line from one client: expected stream is chars 0..min(len,16)-1 on the latched row,
  // done arriving min(len,16)+2+stall cycles after the grant cycle.
  task automatic run_line(input int c, input logic row, input logic [4:0] len,
                          input logic [8*NCHAR-1:0] data, input int stall_pos,
                          input int stall_len, input int exp_gd);
    int n;
    int stall;
    int c0;
    int budget;
    n = (int'(len) > NCHAR) ? NCHAR : int'(len);
    stall = (stall_pos >= 1 && stall_pos < n) ? stall_len : 0;
    clear_obs();
    c0 = cyc;
    drive_client(c, 1'b1, row, len, data);
    budget = 0;
    while (gnt_c.size() == 0 && budget < 64) begin tick(); budget++; end
    chk("gnt_seen", 32'(gnt_c.size()), 32'd1);
    if (gnt_c.size() > 0) begin
      chk("gnt_client", 32'(gnt_c[0]), 32'(c));
      if (exp_gd >= 0) chk("gnt_delay", 32'(gnt_t[0] - c0), 32'(exp_gd));
    end
    drive_client(c, 1'b0, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), rand_data());
    if (stall > 0) begin
      repeat (stall_pos - 1) tick();
      bus.lcd_busy = 1'b1;
      for (int s = 0; s < stall; s++) begin
        #1;
        chk("stall_we", 32'(bus.lcd_we), 32'd0);
        chk("stall_col", 32'(bus.lcd_col), 32'(stall_pos));
        tick();
      end
      bus.lcd_busy = 1'b0;
    end
    budget = 0;
    while (done_c.size() == 0 && budget < 64) begin tick(); budget++; end
    chk("done_seen", 32'(done_c.size()), 32'd1);
    if (done_c.size() > 0 && gnt_t.size() > 0) begin
      chk("done_client", 32'(done_c[0]), 32'(c));
      chk("done_latency", 32'(done_t[0] - gnt_t[0]), 32'(n + 2 + stall));
    end
    chk("write_count", 32'(wq.size()), 32'(n));
    for (int k = 0; k < n && k < wq.size(); k++) begin
      chk("write_row", 32'(wq[k].row), 32'(row));
      chk("write_col", 32'(wq[k].col), 32'(k));
      chk("write_char", 32'(wq[k].ch), 32'(data[8*k +: 8]));
    end
    chk("update_count", 32'(upd_n), 32'd1);
    chk("gnt_once", 32'(gnt_c.size()), 32'd1);
    last_served = c;
  endtask

  initial begin
    logic [8*NCHAR-1:0] d0;
    logic [8*NCHAR-1:0] d1;
    int budget;
    int w;
    int n;
    int sp;

    rst = 1'b1;
    bus.lcd_busy = 1'b1;
    drive_client(0, 1'b0, 1'b0, 5'd0, '0);
    drive_client(1, 1'b0, 1'b0, 5'd0, '0);
    repeat (2) tick();
    chk("reset_outputs", outs(), 32'd0);

    // Driver still initialising: a pending request must not be accepted.
    clear_obs();
    rst = 1'b0;
    drive_client(0, 1'b1, 1'b1, 5'd3, 128'h434241);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("init_active", 32'(bus.active), 32'd0);
    end
    chk("init_no_gnt", 32'(gnt_c.size()), 32'd0);
    bus.lcd_busy = 1'b0;
    run_line(0, 1'b1, 5'd3, 128'h434241, 0, 0, 2);

    run_line(1, 1'b0, 5'd4, rand_data(), 1, 2, 1);

    // Both clients hold requests: grants alternate starting from the pointer's choice.
    clear_obs();
    d0 = rand_data();
    d1 = rand_data();
    drive_client(0, 1'b1, 1'b0, 5'd2, d0);
    drive_client(1, 1'b1, 1'b1, 5'd3, d1);
    budget = 0;
    while (done_c.size() < 3 && budget < 100) begin tick(); budget++; end
    drive_client(0, 1'b0, 1'b0, 5'd0, '0);
    drive_client(1, 1'b0, 1'b0, 5'd0, '0);
    chk("rr_done_count", 32'(done_c.size()), 32'd3);
    chk("rr_gnt_count", 32'(gnt_c.size()), 32'd3);
    chk("rr_write_count", 32'(wq.size()), 32'd7);
    w = (last_served == 0) ? 1 : 0;
    chk("rr_first_is_0", 32'(w), 32'(gnt_c.size() > 0 ? gnt_c[0] : 2));
    for (int i = 0; i < 3; i++) begin
      if (i < gnt_c.size())  chk("rr_gnt_order", 32'(gnt_c[i]), 32'(w));
      if (i < done_c.size()) chk("rr_done_order", 32'(done_c[i]), 32'(w));
      if (i < 2 && i + 1 < gnt_t.size() && i < done_t.size())
        chk("rr_idle_gap", 32'(gnt_t[i+1] - done_t[i]), 32'd2);
      last_served = w;
      w = 1 - w;
    end

    run_line(0, 1'b0, 5'd0, rand_data(), 0, 0, 1);
    run_line(0, 1'b1, 5'd20, rand_data(), 0, 0, 1);

    for (int t = 0; t < 10; t++) begin
      logic [4:0] l;
      l = 5'($urandom_range(0, 31));
      n = (int'(l) > NCHAR) ? NCHAR : int'(l);
      sp = (n >= 2) ? int'($urandom_range(1, n - 1)) : 0;
      run_line(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), l, rand_data(), sp,
               int'($urandom_range(0, 3)), 1);
    end

    // Reset in the middle of a line aborts it; the held request restarts from column 0.
    clear_obs();
    d0 = rand_data();
    drive_client(0, 1'b1, 1'b1, 5'd10, d0);
    budget = 0;
    while (gnt_c.size() == 0 && budget < 64) begin tick(); budget++; end
    repeat (4) tick();
    chk("pre_reset_col", 32'(bus.lcd_col), 32'd5);
    rst = 1'b1;
    #1;
    chk("abort_outputs", outs(), 32'd0);
    tick();
    rst = 1'b0;
    bus.lcd_busy = 1'b1;
    tick();
    bus.lcd_busy = 1'b0;
    chk("abort_no_done", 32'(done_c.size()), 32'd0);
    last_served = 1;
    run_line(0, 1'b1, 5'd10, d0, 0, 0, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
